// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - four-approach phase scheduler with min/max green and clearance timing
// Preemption request/acknowledge is built only when TRAFFIC_PREEMPT_EN is defined.
module traffic_phase_scheduler #(
   parameter int MIN_GREEN = 3,
   parameter int MAX_GREEN = 12,
   parameter int YELLOW_T  = 2,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_i,
   input  logic             req_e_i,
   input  logic             req_nl_i,
   input  logic             req_el_i,
   input  logic             req_w_i,
   input  logic             ovr_req_i,
   input  logic [1:0]       ovr_phase_i,
   output logic [1:0]       phase_o,
   output logic             green_o,
   output logic             yellow_o,
   output logic             allred_o,
   output logic [2:0]       pending_o,
   output logic [CNT_W-1:0] green_cnt_o,
   output logic             ovr_ack_o
);
   localparam logic [1:0] S_GREEN  = 2'd0;
   localparam logic [1:0] S_YELLOW = 2'd1;
   localparam logic [1:0] S_ALLRED = 2'd2;

   localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_GREEN);
   localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_T - 1);

   logic [1:0]       state_q, state_d;
   logic [1:0]       phase_q, phase_d;
   logic [1:0]       next_phase_q, next_phase_d;
   logic [CNT_W-1:0] green_cnt_q, green_cnt_d;
   logic [CNT_W-1:0] ycnt_q, ycnt_d;
   logic [2:0]       pending_q, pending_d;
   logic             ovr_ack_q, ovr_ack_d;
   logic             ovr_pend_q, ovr_pend_d;

   logic [2:0] demand;
   logic [2:0] cur_onehot;
   logic [2:0] other;
   logic       cur_demand;
   logic [1:0] p1, p2, rr_next;
   logic       norm_exit;
   logic       enter_green;
   logic       ovr_same, ovr_switch;

   assign demand      = {req_el_i, req_nl_i, req_w_i | req_e_i};
   assign cur_onehot  = 3'b001 << phase_q;
   assign other       = pending_q & ~cur_onehot;
   assign cur_demand  = |(demand & cur_onehot);
   assign p1          = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
   assign p2          = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
   assign rr_next     = ((other & (3'b001 << p1)) != 3'b000) ? p1 : p2;
   assign norm_exit   = (other != 3'b000) &&
                        (((green_cnt_q >= MIN_C) && !cur_demand) || (green_cnt_q >= MAX_C));
   assign enter_green = (state_q == S_ALLRED) && tick_i;

`ifdef TRAFFIC_PREEMPT_EN
   logic ovr_valid;
   assign ovr_valid  = ovr_req_i && (ovr_phase_i != 2'd3);
   assign ovr_same   = ovr_valid && (ovr_phase_i == phase_q);
   assign ovr_switch = ovr_valid && (ovr_phase_i != phase_q);
`else
   logic unused_ovr;
   assign unused_ovr = &{1'b0, ovr_req_i, ovr_phase_i};
   assign ovr_same   = 1'b0;
   assign ovr_switch = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      next_phase_d = next_phase_q;
      green_cnt_d  = green_cnt_q;
      ycnt_d       = ycnt_q;
      ovr_ack_d    = 1'b0;
      ovr_pend_d   = ovr_pend_q;
      pending_d    = pending_q;

      // Clear on green entry beats a same-cycle set.
      for (int p = 0; p < 3; p++) begin
         if (enter_green && (next_phase_q == 2'(p)))
            pending_d[p] = 1'b0;
         else if (demand[p] && !((state_q == S_GREEN) && (phase_q == 2'(p))))
            pending_d[p] = 1'b1;
      end

      case (state_q)
         S_GREEN: begin
            if (tick_i && (green_cnt_q < MAX_C))
               green_cnt_d = green_cnt_q + 1'b1;
            if (ovr_same)
               ovr_ack_d = ~ovr_ack_q;
            if (ovr_switch) begin
               state_d      = S_YELLOW;
               ycnt_d       = '0;
               next_phase_d = ovr_phase_i;
               ovr_pend_d   = 1'b1;
            end else if (norm_exit) begin
               state_d      = S_YELLOW;
               ycnt_d       = '0;
               next_phase_d = rr_next;
            end
         end
         S_YELLOW: begin
            if (tick_i) begin
               if (ycnt_q == Y_LAST) begin
                  state_d = S_ALLRED;
                  ycnt_d  = '0;
               end else begin
                  ycnt_d = ycnt_q + 1'b1;
               end
            end
         end
         default: begin
            if (tick_i) begin
               state_d     = S_GREEN;
               phase_d     = next_phase_q;
               green_cnt_d = '0;
               if (ovr_pend_q) begin
                  ovr_ack_d  = 1'b1;
                  ovr_pend_d = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_GREEN;
         phase_q      <= 2'd0;
         next_phase_q <= 2'd0;
         green_cnt_q  <= '0;
         ycnt_q       <= '0;
         pending_q    <= 3'b000;
         ovr_ack_q    <= 1'b0;
         ovr_pend_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         next_phase_q <= next_phase_d;
         green_cnt_q  <= green_cnt_d;
         ycnt_q       <= ycnt_d;
         pending_q    <= pending_d;
         ovr_ack_q    <= ovr_ack_d;
         ovr_pend_q   <= ovr_pend_d;
      end
   end

   assign phase_o     = phase_q;
   assign green_o     = (state_q == S_GREEN);
   assign yellow_o    = (state_q == S_YELLOW);
   assign allred_o    = (state_q == S_ALLRED);
   assign pending_o   = pending_q;
   assign green_cnt_o = green_cnt_q;
   assign ovr_ack_o   = ovr_ack_q;
endmodule
